// File: rtl/logs_pkg.sv
// logs_pkg -- shared definitions for the logs tone-voice family.
// Holds the voice state encoding and the default note-record field widths.
// The future multi-voice wrapper reuses these so every voice agrees on them.
package logs_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PLAY = 1'b1
   } state_e;

   // Default note-record field widths and tick size.
   localparam int LOGS_P_WIDTH   = 12;  // half-period field, clocks
   localparam int LOGS_D_WIDTH   = 8;   // duration field, ticks
   localparam int LOGS_TICK_LOG2 = 10;  // one tick = 2^TICK_LOG2 clocks

endpackage

// File: rtl/logs_voice_if.sv
// logs_voice_if -- note-command handshake bus of one voice.
//   cmd_valid       : master offers a note command
//   cmd_ready       : slave can take the command this cycle
//   cmd_half_period : clocks per square-wave half cycle (0 = rest)
//   cmd_duration    : note length in ticks (0 = discard)
// A command transfers on a clock edge where cmd_valid && cmd_ready.
interface logs_voice_if import logs_pkg::*; #(
   parameter int P_WIDTH = LOGS_P_WIDTH,
   parameter int D_WIDTH = LOGS_D_WIDTH
);

   logic               cmd_valid;
   logic               cmd_ready;
   logic [P_WIDTH-1:0] cmd_half_period;
   logic [D_WIDTH-1:0] cmd_duration;

   modport master (
      output cmd_valid,
      output cmd_half_period,
      output cmd_duration,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_half_period,
      input  cmd_duration,
      output cmd_ready
   );

endinterface

// File: rtl/logs_downcounter.sv
// logs_downcounter -- loadable down-counter with a zero flag.
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : load load_val on the next edge (wins over dec)
//   load_val     : value to load
//   dec          : decrement on the next edge; holds at zero, never wraps
//   zero         : count is zero (registered state, no input path)
module logs_downcounter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/logs_voice.sv
// logs_voice -- single-voice square-wave tone sequencer.
// Takes (half-period, duration) note commands, buffers one pending note and
// plays each note for exactly duration * 2^TICK_LOG2 clocks, joining notes
// back-to-back with no gap.
//   clk, reset_n : clock, asynchronous active-low reset
//   cmd          : note-command handshake (slave side); cmd_ready is
//                  !pending && !stop
//   stop         : synchronous abort, flushes current and pending notes
//   audio_out    : square wave to mixer audio_in bit (registered)
//   active       : note or rest playing, drives mixer audio_mask bit
//   note_done    : one-cycle pulse after a note ends or is discarded
module logs_voice import logs_pkg::*; #(
   parameter int P_WIDTH   = LOGS_P_WIDTH,
   parameter int D_WIDTH   = LOGS_D_WIDTH,
   parameter int TICK_LOG2 = LOGS_TICK_LOG2
) (
   input  logic        clk,
   input  logic        reset_n,
   logs_voice_if.slave cmd,
   input  logic        stop,
   output logic        audio_out,
   output logic        active,
   output logic        note_done
);

   state_e               state_q, state_d;
   logic                 pend_valid_q, pend_valid_d;
   logic [P_WIDTH-1:0]   pend_half_q, pend_half_d;
   logic [D_WIDTH-1:0]   pend_dur_q, pend_dur_d;
   logic [P_WIDTH-1:0]   cur_half_q, cur_half_d;
   logic [TICK_LOG2-1:0] presc_q, presc_d;
   logic                 audio_q, audio_d;
   logic                 note_done_q, note_done_d;

   logic                 hp_load, hp_dec, hp_zero;
   logic [P_WIDTH-1:0]   hp_val;
   logic                 du_load, du_dec, du_zero;
   logic [D_WIDTH-1:0]   du_val;

   logic                 accept;
   logic                 load_pend;
   logic                 tick_first;
   logic                 tick_last;

   assign cmd.cmd_ready = !pend_valid_q && !stop;
   assign accept        = cmd.cmd_valid && cmd.cmd_ready;

   // First and last clock of each tick.
   assign tick_first = (presc_q == '0);
   assign tick_last  = (presc_q == '1);

   always_comb begin
      state_d      = state_q;
      pend_valid_d = pend_valid_q;
      pend_half_d  = pend_half_q;
      pend_dur_d   = pend_dur_q;
      cur_half_d   = cur_half_q;
      presc_d      = presc_q;
      audio_d      = audio_q;
      note_done_d  = 1'b0;
      hp_load      = 1'b0;
      hp_dec       = 1'b0;
      hp_val       = '0;
      du_load      = 1'b0;
      du_dec       = 1'b0;
      du_val       = '0;
      load_pend    = 1'b0;

      if (accept) begin
         pend_valid_d = 1'b1;
         pend_half_d  = cmd.cmd_half_period;
         pend_dur_d   = cmd.cmd_duration;
      end

      if (stop) begin
         state_d      = ST_IDLE;
         pend_valid_d = 1'b0;
         audio_d      = 1'b0;
         presc_d      = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (pend_valid_q) begin
                  pend_valid_d = 1'b0;
                  if (pend_dur_q != '0) begin
                     load_pend = 1'b1;
                     state_d   = ST_PLAY;
                  end else begin
                     note_done_d = 1'b1;
                  end
               end
            end

            ST_PLAY: begin
               presc_d = tick_last ? '0 : presc_q + TICK_LOG2'(1);

               // Rests (half-period 0) leave the wave counter idle and low.
               if (cur_half_q != '0) begin
                  if (hp_zero) begin
                     hp_load = 1'b1;
                     hp_val  = cur_half_q - P_WIDTH'(1);
                     audio_d = !audio_q;
                  end else begin
                     hp_dec = 1'b1;
                  end
               end

               // The duration counter steps at the start of each tick, so it
               // holds the number of ticks left after the current one; zero
               // on the last clock of a tick therefore marks the note end.
               if (tick_first) begin
                  du_dec = 1'b1;
               end

               if (tick_last && du_zero) begin
                  note_done_d = 1'b1;
                  if (pend_valid_q) begin
                     pend_valid_d = 1'b0;
                     if (pend_dur_q != '0) begin
                        load_pend = 1'b1;
                     end else begin
                        state_d = ST_IDLE;
                        audio_d = 1'b0;
                     end
                  end else begin
                     state_d = ST_IDLE;
                     audio_d = 1'b0;
                  end
               end
            end

            default: state_d = ST_IDLE;
         endcase
      end

      // Note load overrides the wave/tick updates made above.
      if (load_pend) begin
         cur_half_d = pend_half_q;
         hp_load    = 1'b1;
         hp_val     = (pend_half_q == '0) ? '0 : pend_half_q - P_WIDTH'(1);
         audio_d    = (pend_half_q != '0);
         presc_d    = '0;
         du_load    = 1'b1;
         du_val     = pend_dur_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         pend_valid_q <= 1'b0;
         pend_half_q  <= '0;
         pend_dur_q   <= '0;
         cur_half_q   <= '0;
         presc_q      <= '0;
         audio_q      <= 1'b0;
         note_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         pend_valid_q <= pend_valid_d;
         pend_half_q  <= pend_half_d;
         pend_dur_q   <= pend_dur_d;
         cur_half_q   <= cur_half_d;
         presc_q      <= presc_d;
         audio_q      <= audio_d;
         note_done_q  <= note_done_d;
      end
   end

   logs_downcounter #(.W(P_WIDTH)) u_half_cnt (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (hp_load),
      .load_val (hp_val),
      .dec      (hp_dec),
      .zero     (hp_zero)
   );

   logs_downcounter #(.W(D_WIDTH)) u_dur_cnt (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (du_load),
      .load_val (du_val),
      .dec      (du_dec),
      .zero     (du_zero)
   );

   assign audio_out = audio_q;
   assign active    = (state_q == ST_PLAY);
   assign note_done = note_done_q;

endmodule

// File: tb/tb_logs_voice.sv
// tb_logs_voice -- self-checking bench for logs_voice.
// Every cycle the DUT outputs are compared with a note-level reference model
// that tracks the playing note as (half-period, length, elapsed clocks).
module tb_logs_voice;

   localparam int P_W  = 4;
   localparam int D_W  = 4;
   localparam int T_L  = 2;
   localparam int TICK = 1 << T_L;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   logic stop    = 1'b0;
   logic audio_out;
   logic active;
   logic note_done;

   logs_voice_if #(.P_WIDTH(P_W), .D_WIDTH(D_W)) cmd_if ();

   logs_voice #(.P_WIDTH(P_W), .D_WIDTH(D_W), .TICK_LOG2(T_L)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cmd       (cmd_if),
      .stop      (stop),
      .audio_out (audio_out),
      .active    (active),
      .note_done (note_done)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Reference model state.
   bit m_play, m_pv, m_done;
   int m_half, m_len, m_el, m_ph, m_pd;

   // Observations gathered by step().
   bit          obs_acc;
   bit          prev_active;
   int          cnt_active, cnt_high, cnt_done, cnt_rise;
   int          first_done_cyc, last_done_cyc, prev_done_cyc, acc_cyc;
   logic [63:0] act_bits;

   typedef struct {
      int          half;
      int          dur;
      int          exp_active;
      int          exp_high;
      logic [15:0] exp_pat;
   } vec_t;
   vec_t vecs[9];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
      end
   endtask

   task automatic start_note(input int h, input int d);
      m_play = 1'b1;
      m_half = h;
      m_len  = d * TICK;
      m_el   = 0;
   endtask

   task automatic model_reset();
      m_play = 1'b0;
      m_pv   = 1'b0;
      m_done = 1'b0;
   endtask

   // Advance the model across one clock edge using the inputs of that cycle.
   task automatic model_update();
      bit acc;
      bit nd;
      if (!reset_n) begin
         model_reset();
         return;
      end
      acc = cmd_if.cmd_valid && !m_pv && !stop;
      nd  = 1'b0;
      if (stop) begin
         m_play = 1'b0;
         m_pv   = 1'b0;
      end else if (m_play) begin
         if (m_el == m_len - 1) begin
            nd = 1'b1;
            if (m_pv) begin
               m_pv = 1'b0;
               if (m_pd != 0) start_note(m_ph, m_pd);
               else m_play = 1'b0;
            end else begin
               m_play = 1'b0;
            end
         end else begin
            m_el++;
         end
      end else if (m_pv) begin
         m_pv = 1'b0;
         if (m_pd != 0) start_note(m_ph, m_pd);
         else nd = 1'b1;
      end
      if (acc) begin
         m_pv = 1'b1;
         m_ph = int'(cmd_if.cmd_half_period);
         m_pd = int'(cmd_if.cmd_duration);
      end
      m_done = nd;
   endtask

   // Compare this cycle's outputs, record observations, cross one edge.
   task automatic step();
      int e_audio;
      #1;
      e_audio = 0;
      if (m_play && m_half != 0) e_audio = ((m_el / m_half) % 2 == 0) ? 1 : 0;
      check("audio_out", int'(audio_out), e_audio);
      check("active", int'(active), int'(m_play));
      check("note_done", int'(note_done), int'(m_done));
      check("cmd_ready", int'(cmd_if.cmd_ready), int'(!m_pv && !stop));
      obs_acc = cmd_if.cmd_valid && cmd_if.cmd_ready;
      if (active) begin
         cnt_active++;
         act_bits = {act_bits[62:0], audio_out};
         if (audio_out) cnt_high++;
         if (!prev_active) cnt_rise++;
      end
      prev_active = active;
      if (note_done) begin
         cnt_done++;
         prev_done_cyc = last_done_cyc;
         last_done_cyc = cyc;
         if (first_done_cyc < 0) first_done_cyc = cyc;
      end
      if (obs_acc) acc_cyc = cyc;
      @(posedge clk);
      model_update();
      cyc++;
      #1;
   endtask

   task automatic clear_stats();
      cnt_active     = 0;
      cnt_high       = 0;
      cnt_done       = 0;
      cnt_rise       = 0;
      act_bits       = '0;
      first_done_cyc = -1;
      last_done_cyc  = -1;
      prev_done_cyc  = -1;
      acc_cyc        = -1;
   endtask

   task automatic send(input int h, input int d, input bit keep_valid);
      cmd_if.cmd_valid       = 1'b1;
      cmd_if.cmd_half_period = P_W'(h);
      cmd_if.cmd_duration    = D_W'(d);
      obs_acc = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (obs_acc) break;
      end
      if (!obs_acc) check("send_timeout", 0, 1);
      if (!keep_valid) cmd_if.cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((m_play || m_pv || m_done) && n < budget) begin
         step();
         n++;
      end
      if (m_play || m_pv || m_done) check("idle_timeout", 0, 1);
   endtask

   initial begin
      int acc3;
      int done_snap;
      int act_snap;

      vecs[0] = '{3, 2,  8, 5, 16'h00E3};
      vecs[1] = '{1, 1,  4, 2, 16'h000A};
      vecs[2] = '{2, 1,  4, 2, 16'h000C};
      vecs[3] = '{0, 1,  4, 0, 16'h0000};
      vecs[4] = '{2, 0,  0, 0, 16'h0000};
      vecs[5] = '{5, 1,  4, 4, 16'h000F};
      vecs[6] = '{7, 3, 12, 7, 16'h0FE0};
      vecs[7] = '{1, 2,  8, 4, 16'h00AA};
      vecs[8] = '{4, 3, 12, 8, 16'h0F0F};

      cmd_if.cmd_valid       = 1'b0;
      cmd_if.cmd_half_period = '0;
      cmd_if.cmd_duration    = '0;
      model_reset();
      clear_stats();
      prev_active = 1'b0;

      // Reset held for 3 clocks.
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_audio", int'(audio_out), 0);
      end
      reset_n = 1'b1;

      // Single notes from idle, table driven.
      for (int v = 0; v < 9; v++) begin
         clear_stats();
         send(vecs[v].half, vecs[v].dur, 1'b0);
         wait_idle(200);
         check("tbl_active", cnt_active, vecs[v].exp_active);
         check("tbl_high", cnt_high, vecs[v].exp_high);
         check("tbl_pattern", int'(act_bits[15:0]), int'(vecs[v].exp_pat));
         check("tbl_done", cnt_done, 1);
      end

      // Gapless pair.
      clear_stats();
      send(1, 1, 1'b0);
      send(2, 1, 1'b0);
      wait_idle(200);
      check("gap_active", cnt_active, 8);
      check("gap_rises", cnt_rise, 1);
      check("gap_pattern", int'(act_bits[7:0]), 8'hAC);
      check("gap_done", cnt_done, 2);
      check("gap_done_spacing", last_done_cyc - prev_done_cyc, 4);

      // Back-pressure: cmd_valid held across three commands.
      clear_stats();
      send(1, 1, 1'b1);
      send(2, 1, 1'b1);
      send(3, 1, 1'b0);
      acc3 = acc_cyc;
      wait_idle(200);
      check("bp_third_after_end", int'(first_done_cyc >= 0 && acc3 >= first_done_cyc), 1);
      check("bp_active", cnt_active, 12);
      check("bp_rises", cnt_rise, 1);
      check("bp_pattern", int'(act_bits[11:0]), 12'hACE);
      check("bp_done", cnt_done, 3);

      // Rest, then zero-duration note from idle.
      clear_stats();
      send(0, 1, 1'b0);
      wait_idle(200);
      send(2, 0, 1'b0);
      wait_idle(200);
      check("rest_active", cnt_active, 4);
      check("rest_high", cnt_high, 0);
      check("rest_done", cnt_done, 2);

      // Zero-duration note pending at note end: discarded without a pulse.
      clear_stats();
      send(1, 1, 1'b0);
      send(2, 0, 1'b0);
      wait_idle(200);
      check("zdisc_active", cnt_active, 4);
      check("zdisc_done", cnt_done, 1);

      // Abort five clocks into a dur=3 note with a note pending.
      clear_stats();
      send(2, 3, 1'b0);
      send(1, 2, 1'b0);
      for (int i = 0; i < 50 && cnt_active < 4; i++) step();
      stop                   = 1'b1;
      cmd_if.cmd_valid       = 1'b1;
      cmd_if.cmd_half_period = P_W'(3);
      cmd_if.cmd_duration    = D_W'(1);
      step();
      check("abort_active_5", cnt_active, 5);
      check("abort_same_cycle_accept", int'(obs_acc), 0);
      stop             = 1'b0;
      cmd_if.cmd_valid = 1'b0;
      done_snap = cnt_done;
      act_snap  = cnt_active;
      step();
      check("abort_audio", int'(audio_out), 0);
      check("abort_active", int'(active), 0);
      check("abort_done", int'(note_done), 0);
      for (int i = 0; i < 8; i++) step();
      check("abort_no_more_play", cnt_active, act_snap);
      check("abort_no_more_done", cnt_done, done_snap);

      // Asynchronous reset in the middle of a note.
      clear_stats();
      send(3, 3, 1'b0);
      step();
      check("pre_rst_active", int'(active), 1);
      check("pre_rst_audio", int'(audio_out), 1);
      reset_n = 1'b0;
      #1;
      check("arst_audio", int'(audio_out), 0);
      check("arst_active", int'(active), 0);
      check("arst_done", int'(note_done), 0);
      check("arst_ready", int'(cmd_if.cmd_ready), 1);
      model_reset();
      step();
      step();
      reset_n = 1'b1;
      step();
      step();

      // Randomised traffic against the model.
      for (int i = 0; i < 400; i++) begin
         stop                   = ($urandom_range(0, 39) == 0);
         cmd_if.cmd_valid       = ($urandom_range(0, 2) == 0);
         cmd_if.cmd_half_period = P_W'($urandom_range(0, 15));
         cmd_if.cmd_duration    = D_W'($urandom_range(0, 3));
         step();
      end
      stop             = 1'b0;
      cmd_if.cmd_valid = 1'b0;
      wait_idle(200);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/logs_voice.md
# logs_voice

Single-voice tone sequencer feeding one bit of the mixer's `audio_in`/`audio_mask` bus. It accepts note commands (half-period, duration) over a valid/ready handshake and buffers one pending note. It plays each note as a 1-bit square wave for an exact number of clocks, so consecutive notes join with no gap. Its `active` output drives the matching `audio_mask` bit, so a silent voice adds nothing to the PWM duty cycle.

## Interface
Parameters:
- `P_WIDTH`, 12: width of half-period field, in clocks.
- `D_WIDTH`, 8: width of duration field, in ticks.
- `TICK_LOG2`, 10: one duration tick = 2^TICK_LOG2 clocks.

Ports:
- `clk`  input  1  clock.
- `reset_n`  input  1  reset, asynchronous, active-low.
- `cmd_valid`  input  1  note command offered.
- `cmd_ready`  output  1  voice can accept a command; equals `!pend_valid && !stop`.
- `cmd_half_period`  input  P_WIDTH  clocks per square-wave half cycle; 0 = rest.
- `cmd_duration`  input  D_WIDTH  note length in ticks; 0 = discard.
- `stop`  input  1  synchronous abort; flushes current and pending notes.
- `audio_out`  output  1  square-wave line to mixer `audio_in[i]`.
- `active`  output  1  high while a note (including a rest) plays; drives mixer `audio_mask[i]`.
- `note_done`  output  1  one-cycle pulse when a note ends or is discarded.

## Operation
- Reset values: `audio_out`=0, `active`=0, `note_done`=0, `cmd_ready`=1. State is IDLE, the pending register is empty, and all counters are 0.
- Pending register: 1 entry. Loaded on `cmd_valid && cmd_ready`. Emptied when its note is loaded into the current-note registers.
- States:
  - IDLE: if pending is valid, load it on the next edge.
    - Duration ≠ 0: go to PLAY.
    - Duration = 0: stay in IDLE, pulse `note_done`.
  - PLAY: runs the half-period counter and the duration counter.
    - A half-period counter reload toggles `audio_out`.
    - A rest (half-period 0) holds `audio_out` at 0.
    - The tick prescaler counts 2^TICK_LOG2 clocks per tick; the duration counter decrements once per tick.
- Note end (last clock of the final tick):
  - Pulse `note_done`.
  - If pending is valid with duration ≠ 0, load it on the same edge and stay in PLAY (gapless).
  - If pending is valid with duration 0, discard it with no extra `note_done` pulse, then go to IDLE.
  - Otherwise go to IDLE: `audio_out`=0, `active`=0.
- Note load:
  - `audio_out`=1 (0 for a rest).
  - Half-period counter = half_period−1.
  - Prescaler = 0.
  - Duration counter = duration.
- `stop`:
  - On the next edge: state IDLE, pending emptied, `audio_out`=0, `active`=0, no `note_done`.
  - Any command offered in the same cycle is not accepted.
  - `stop` takes priority over note end and over loading.
- Half-period = 1: `audio_out` toggles every clock.
- Counters wrap never: every counter reloads or stops explicitly.

## Timing
- Edge k: command accepted. Edge k+1 (from IDLE): `active`=1, `audio_out`=1. Command-to-sound latency is 2 cycles, counting the presentation cycle.
- Note length is exactly duration × 2^TICK_LOG2 clocks of `active`=1.
- Square-wave period is 2 × half_period clocks. A partial final cycle is truncated at note end.
- `note_done` is high for the cycle immediately after the note's last PLAY cycle.
- `cmd_ready` drops the cycle after acceptance and rises the cycle after the pending note is loaded.
- All outputs are registered; no combinational path from inputs to `audio_out`, `active` or `note_done`.
- `reset_n` deassertion is synchronised externally. Outputs are held at reset values while it is low.

## Structure
- Shared package `logs_pkg`: state encodings (IDLE, PLAY) and the note-record field widths, which the future multi-voice wrapper reuses.
- One sub-module, `logs_downcounter`: a loadable down-counter with a zero flag. Instantiated for both the half-period counter and the duration counter. The prescaler is a plain TICK_LOG2-bit incrementer whose all-ones state marks a tick.

## Test plan
Bench parameters: TICK_LOG2=2, P_WIDTH=4, D_WIDTH=4.
- Reset and idle check: hold `reset_n`=0 for 3 clocks, release, then send command half=3, dur=2. Required: `audio_out`=0 before release; high for 3 clocks, low 3, high 2; `active` high exactly 8 clocks; `note_done` pulses once.
- Gapless pair: send (half=1, dur=1) then (half=2, dur=1) back-to-back. Required: `active` continuously high for 8 clocks; `audio_out` pattern 1010 then 1100; two `note_done` pulses 4 clocks apart.
- Back-pressure: hold `cmd_valid`=1 for 3 commands. Required: `cmd_ready`=0 while pending is full; the third command is accepted only after the first note ends; no command is lost or duplicated.
- Rest and zero-duration: send (half=0, dur=1), then (half=2, dur=0). Required: `active`=1 with `audio_out`=0 for 4 clocks; the zero-duration note produces one `note_done` with `active` staying 0.
- Abort: `stop` pulsed 5 clocks into a dur=3 note, with a second command pending and a third `cmd_valid` asserted in the same cycle. Required: next cycle `audio_out`=0 and `active`=0, no `note_done`; the pending note and the same-cycle command are discarded.
- Async reset mid-note: drop `reset_n` between clock edges. Required: outputs return to reset values immediately, with no clock edge needed.
